// File: rtl/square_voice_mixer.sv
// square_voice_mixer
//   NUM_CH independent square/pulse voices with a programmable period and duty
//   cycle. Their contributions are summed into one signed sample per AC97 frame.
//   Each voice keeps a shadow configuration and an active configuration. The
//   shadow is copied into the active set only when the voice is idle or its
//   phase wraps, so retuning a voice never produces a partial cycle.
//
// Ports
//   BIT_CLK      AC97 bit clock. All logic runs on its rising edge.
//   RESET_N      asynchronous reset, active low.
//   frame_sig    one-cycle pulse per 48 kHz frame.
//   en           configuration write strobe for channel CH_SEL.
//   CH_SEL       channel targeted by en.
//   PERIOD_IN    period in frames. A period of 0 silences the channel.
//   DUTY_IN      high fraction of the cycle, in units of 1/256.
//   CH_ON_IN     channel enable.
//   MIX_OUT      registered, signed mix of all channels.
//   MIX_VALID    one-cycle pulse when MIX_OUT updates.
//   CYCLE_START  per-channel pulse in the cycle after the phase restarts at 0.
//   PENDING      per-channel flag: shadow configuration is waiting to apply.

module square_voice_ch #(
    parameter int PER_W = 10,
    parameter int OUT_W = 18,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_sig,
    input  logic             wr,
    input  logic [PER_W-1:0] period_in,
    input  logic [7:0]       duty_in,
    input  logic             on_in,
    output logic [OUT_W-1:0] contrib,
    output logic             cycle_start,
    output logic             pending
);
    // Sized so that NUM_CH full-scale voices sum without overflow.
    localparam logic [OUT_W-1:0] LVL = OUT_W'((1 << (OUT_W - 1 - CH_W)) - 1);

    logic [PER_W-1:0] sh_per_q, sh_per_d;
    logic [7:0]       sh_duty_q, sh_duty_d;
    logic             sh_on_q, sh_on_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W:0]   thr_q, thr_d;
    logic             on_q, on_d;
    logic [PER_W-1:0] phase_q, phase_d;
    logic             pend_q, pend_d;
    logic             cs_q, cs_d;

    logic [PER_W-1:0] src_per;
    logic [7:0]       src_duty;
    logic             src_on;
    logic [PER_W+8:0] thr_prod;
    logic             active, wrap, apply;

    always_comb begin
        // A write that lands on the apply edge bypasses the shadow.
        src_per  = wr ? period_in : sh_per_q;
        src_duty = wr ? duty_in   : sh_duty_q;
        src_on   = wr ? on_in     : sh_on_q;
        // Width of the low part = period * (256 - duty) / 256. The top bits hold the result.
        thr_prod = {9'd0, src_per} * {{PER_W{1'b0}}, 9'd256 - {1'b0, src_duty}};

        active = on_q && (per_q != '0);
        wrap   = active && (phase_q == per_q - PER_W'(1));
        apply  = frame_sig && pend_q && (!active || wrap);

        sh_per_d  = sh_per_q;
        sh_duty_d = sh_duty_q;
        sh_on_d   = sh_on_q;
        per_d     = per_q;
        thr_d     = thr_q;
        on_d      = on_q;
        phase_d   = phase_q;
        pend_d    = pend_q;
        cs_d      = 1'b0;

        if (wr) begin
            sh_per_d  = period_in;
            sh_duty_d = duty_in;
            sh_on_d   = on_in;
            pend_d    = 1'b1;
        end

        if (apply) begin
            per_d   = src_per;
            thr_d   = thr_prod[PER_W+8:8];
            on_d    = src_on;
            phase_d = '0;
            pend_d  = 1'b0;
            cs_d    = 1'b1;
        end else if (frame_sig) begin
            if (active) begin
                phase_d = wrap ? '0 : phase_q + PER_W'(1);
                cs_d    = wrap;
            end else begin
                phase_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_per_q  <= '0;
            sh_duty_q <= '0;
            sh_on_q   <= 1'b0;
            per_q     <= '0;
            thr_q     <= '0;
            on_q      <= 1'b0;
            phase_q   <= '0;
            pend_q    <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sh_per_q  <= sh_per_d;
            sh_duty_q <= sh_duty_d;
            sh_on_q   <= sh_on_d;
            per_q     <= per_d;
            thr_q     <= thr_d;
            on_q      <= on_d;
            phase_q   <= phase_d;
            pend_q    <= pend_d;
            cs_q      <= cs_d;
        end
    end

    // The low part comes first in each cycle. When duty is 0, THR equals PER and the output stays low.
    always_comb begin
        if (!active)                  contrib = '0;
        else if ({1'b0, phase_q} < thr_q) contrib = -LVL;
        else                          contrib = LVL;
    end

    assign cycle_start = cs_q;
    assign pending     = pend_q;
endmodule

module square_voice_mixer #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 18,
    parameter int PER_W  = 10,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              BIT_CLK,
    input  logic              RESET_N,
    input  logic              frame_sig,
    input  logic              en,
    input  logic [CH_W-1:0]   CH_SEL,
    input  logic [PER_W-1:0]  PERIOD_IN,
    input  logic [7:0]        DUTY_IN,
    input  logic              CH_ON_IN,
    output logic [OUT_W-1:0]  MIX_OUT,
    output logic              MIX_VALID,
    output logic [NUM_CH-1:0] CYCLE_START,
    output logic [NUM_CH-1:0] PENDING
);
    logic [NUM_CH-1:0][OUT_W-1:0] contrib;
    logic [OUT_W-1:0]             mix_q, mix_d;
    logic                         mix_valid_q, mix_valid_d;
    logic                         frame_q, frame_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        square_voice_ch #(
            .PER_W (PER_W),
            .OUT_W (OUT_W),
            .CH_W  (CH_W)
        ) u_ch (
            .clk         (BIT_CLK),
            .rst_n       (RESET_N),
            .frame_sig   (frame_sig),
            .wr          (en && (CH_SEL == CH_W'(c))),
            .period_in   (PERIOD_IN),
            .duty_in     (DUTY_IN),
            .on_in       (CH_ON_IN),
            .contrib     (contrib[c]),
            .cycle_start (CYCLE_START[c]),
            .pending     (PENDING[c])
        );
    end

    // The mix is taken one cycle after frame_sig, so it uses the phases updated on that edge.
    // Modular addition is exact here because the full-scale sum fits in OUT_W.
    always_comb begin
        frame_d     = frame_sig;
        mix_valid_d = frame_q;
        mix_d       = mix_q;
        if (frame_q) begin
            mix_d = '0;
            for (int i = 0; i < NUM_CH; i++) mix_d = mix_d + contrib[i];
        end
    end

    always_ff @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_q     <= 1'b0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
        end
    end

    assign MIX_OUT   = mix_q;
    assign MIX_VALID = mix_valid_q;
endmodule

// File: doc/square_voice_mixer.md
Name: square_voice_mixer

Overview:
- Multi-channel successor to the single square-wave voice generator in the synthesizer audio path.
- Runs NUM_CH independent square/pulse oscillators with programmable period (in AC97 frames) and duty cycle.
- Sums the channels into one signed sample per frame for the AC97 slot formatter.
- Parameter updates are double-buffered and take effect only at a cycle boundary, so retuning never glitches the waveform.

Parameters:
- NUM_CH, 4: number of voices. Power of two, at least 2.
- OUT_W, 18: mixed sample width, two's complement.
- PER_W, 10: period counter width, in frames.
- CH_W, log2(NUM_CH): width of the channel select.

Ports:
- BIT_CLK  in  1  AC97 bit clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- frame_sig  in  1  one-cycle pulse per 48 kHz frame.
- en  in  1  write strobe for channel configuration.
- CH_SEL  in  CH_W  channel targeted by en.
- PERIOD_IN  in  PER_W  period in frames. 0 means silent.
- DUTY_IN  in  8  high fraction, in units of 1/256.
- CH_ON_IN  in  1  channel enable.
- MIX_OUT  out  OUT_W  signed mixed sample, registered.
- MIX_VALID  out  1  one-cycle pulse when MIX_OUT updates.
- CYCLE_START  out  NUM_CH  per-channel one-cycle pulse when the phase restarts at 0.
- PENDING  out  NUM_CH  shadow configuration is waiting to be applied.

Behaviour:
- Reset (asynchronous on RESET_N low, also mid-operation) clears:
  - all shadow and active registers (period, threshold, on), and phase counters;
  - MIX_OUT, MIX_VALID, CYCLE_START and PENDING, all to 0.
- Per-channel state:
  - shadow {period, duty, on};
  - active {PER, THR, ON};
  - PHASE, PER_W bits.
- Write: on an edge with en=1, the shadow of channel CH_SEL captures the inputs and PENDING[CH_SEL] goes to 1.
- Apply event for channel c occurs on an edge with frame_sig=1 and PENDING[c]=1, when either:
  - channel c is idle (PER=0 or ON=0), or
  - PHASE == PER-1 (a wrap).
- On apply:
  - active registers load from the shadow;
  - THR = (period*(256-duty))>>8, computed at full width then stored in PER_W+1 bits;
  - PHASE goes to 0, PENDING[c] goes to 0, and CYCLE_START[c] pulses in the next cycle.
- Write and apply on the same edge, same channel: the incoming PERIOD_IN, DUTY_IN and CH_ON_IN are applied directly, and PENDING[c] ends at 0.
- Advance, on frame_sig=1 with no apply:
  - if PER≥1 and ON=1, PHASE = (PHASE==PER-1) ? 0 : PHASE+1;
  - each wrap pulses CYCLE_START[c] in the next cycle;
  - otherwise PHASE holds at 0.
- Channel level L = 2^(OUT_W-1-CH_W) - 1. Channel contribution:
  - 0 if ON=0 or PER=0;
  - -L if PHASE < THR;
  - +L otherwise.
  - The low portion comes first in every cycle.
- Duty edge cases:
  - duty=0 gives THR=PER, so the channel is constantly -L;
  - PER=1 gives constant +L for duty≥1.
- Mix:
  - on the edge after each frame_sig edge, MIX_OUT = sum of all contributions, computed from the updated phases, and MIX_VALID=1 for that cycle;
  - the maximum magnitude NUM_CH*L fits OUT_W without saturation;
  - between updates MIX_OUT holds its value.
- Latency: frame_sig sampled at edge N gives phase updated at N and MIX_OUT/MIX_VALID at N+1.
- If frame_sig is held high, the block advances every cycle; no error is flagged.
- A PERIOD_IN wider than the counter is impossible by width. Period 0 silences the channel and it contributes 0.

Test Plan:
- Reset, then ch0 loaded with P=48, D=128, ON=1. After the next frame_sig, ch0 PENDING clears. MIX_OUT is -32767 for 24 frames, then +32767 for 24 frames, repeating. CYCLE_START[0] pulses every 48 frames. MIX_VALID pulses once per frame.
- Duty: ch1 loaded with P=10, D=64, ch1 only. THR=7, so the output is -32767 for frames 0..6 and +32767 for frames 7..9, period 10.
- Glitch-free retune: ch0 running P=48, and at PHASE=10 write P=20. PENDING[0]=1 and the old waveform continues to phase 47, then wraps. From then on the period is 20 with THR=10, and PENDING[0]=0.
- Mixing: all four channels loaded with P=2, D=128, ON=1 and applied on the same frame. MIX_OUT alternates -131068 / +131068. Turning ch2 and ch3 off (CH_ON_IN=0, applied at wrap) gives ±65534.
- Simultaneous en and apply on ch3: the incoming values are active immediately and PENDING[3]=0. Writing P=0 to ch3 makes ch3 contribute 0 from the next frame.
- Async reset: RESET_N pulled low between BIT_CLK edges mid-waveform. MIX_OUT, PENDING and CYCLE_START go to 0 without a clock edge. After release the output stays 0 on every frame until channels are reloaded.
